uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- Serial-input end of the board UART link: a 16x-oversampling 8N1 receiver feeding a small first-word-fall-through (FWFT) receive FIFO.
- Pairs with the existing async transmitter.
- Sits between the RxD pin and the CPU-side serial interrupt/MMIO logic.
- Decouples byte arrival from CPU service latency, and reports overrun and framing errors as sticky flags.

Parameters:
- CLK_FREQ, 0, system clock frequency in Hz; must be set by the instantiating module.
- BAUD, 115200, line rate in bits/s.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- RxD  input  1  asynchronous serial line; idles high
- rd_valid  output  1  FIFO non-empty
- rd_data  output  8  FIFO head byte, valid while rd_valid=1
- rd_ack  input  1  pops the head byte at the clock edge if rd_valid=1
- count  output  FIFO_AW+1  bytes currently held
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte dropped because the FIFO was full
- err_clr  input  1  clears frame_err and overrun

Behaviour:
- Reset values:
  - All outputs 0, FIFO empty, FSM in IDLE.
  - Synchronizer flops = 1; armed = 0.
- Synchronizer and tick:
  - RxD passes through 2 flops; rx_s is the second flop. Input-to-rx_s latency is 2 clk.
  - DIV = CLK_FREQ/(BAUD*16), integer-truncated. DIV < 1 is an elaboration error.
  - A tick counter 0..DIV-1 produces a 1-clk tick when it wraps. It is held at 0 in reset.
- Arming: after reset, armed sets on the first tick that samples rx_s=1. IDLE ignores a low line until armed=1, so a mid-frame reset cannot be misread as a start bit.
- FSM (advances only on tick; sc is a 4-bit sample counter, bc is a 3-bit bit counter):
  - IDLE: armed and rx_s=0 -> START, sc=0.
  - START: sc increments each tick. When sc=7 (mid start bit):
    - rx_s=0 -> DATA, sc=0, bc=0.
    - rx_s=1 -> IDLE (glitch; no error).
  - DATA: when sc=15, sample rx_s into shift[7] and shift right, so the byte is LSB-first. Then:
    - bc=7 -> STOP.
    - otherwise bc increments.
  - STOP: when sc=15, sample rx_s:
    - rx_s=1 -> push shift into the FIFO, then IDLE.
    - rx_s=0 -> set frame_err, discard the byte, go to BRK.
  - BRK: wait for a tick with rx_s=1, then IDLE. This handles breaks and long low lines.
- FIFO push/pop:
  - A push writes in the same clk as the stop-bit sample tick. rd_valid rises on the next edge.
  - Full and push without pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same clk: both happen, including when full (no overrun) and when empty? No: when empty, rd_valid=0, so the pop is ignored and the push proceeds.
  - rd_ack while empty: ignored; count does not underflow.
  - Read and write pointers are FIFO_AW bits and wrap modulo depth. count is the occupancy, 0..depth.
  - rd_data is combinational from the head entry. It is undefined but stable while empty.
- Error flags:
  - err_clr has priority over a set in the same clk: the flag reads 0 after that edge. An event in that same clk is lost.
  - Error flags never block reception.
- Reset mid-frame: the partial byte is discarded, FIFO is emptied, flags are cleared, and armed=0.

Test Plan:
All scenarios use CLK_FREQ=3686400 and BAUD=115200, giving DIV=2, 32 clk per bit and 320 clk per frame.
1. Send 0xA5 8N1 -> rd_valid=1 and rd_data=0xA5 within 320+4 clk of the start-bit fall. count=1. rd_ack for 1 clk -> rd_valid=0, count=0.
2. Send 0x01,0x02,0x03,0x04,0x05 back-to-back with no reads -> count=4 and overrun=1. Reads return 01,02,03,04 in order. err_clr -> overrun=0.
3. Start-bit glitch: RxD low for 8 clk, then high -> no push, no error, FSM back in IDLE. A following frame 0x3C is received correctly.
4. Frame 0x55 with the stop bit held low for 64 clk -> frame_err=1, count=0. After the line returns high, frame 0x0F is received (count=1, rd_data=0x0F) and frame_err stays 1.
5. FIFO full (4 bytes), with rd_ack asserted in the same clk as the 5th byte's push -> count stays 4, overrun=0. The head advances and the newest entry is the 5th byte.
6. Assert rst for 1 clk at the middle of data bit 3 while RxD stays low (break) -> no start is accepted until RxD returns high. The next frame 0x81 is received correctly, with frame_err=0.

Source files
------------

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: receive-FIFO read side and error-flag bundle of the UART receiver
// Signals:
//   rd_valid  FIFO non-empty               rd_data  FIFO head byte (FWFT)
//   rd_ack    pop head byte                count    bytes held (0..depth)
//   frame_err sticky stop-bit error        overrun  sticky dropped-byte flag
//   err_clr   clears both sticky flags
// master = receiver side, slave = CPU/MMIO side.
interface uart_rx_buffered_if #(parameter int FIFO_AW = 2);
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_ack;
  logic [FIFO_AW:0] count;
  logic             frame_err;
  logic             overrun;
  logic             err_clr;
  modport master(output rd_valid, rd_data, count, frame_err, overrun, input rd_ack, err_clr);
  modport slave(input rd_valid, rd_data, count, frame_err, overrun, output rd_ack, err_clr);
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 16x-oversampling 8N1 UART receiver feeding a small FWFT receive FIFO
// Ports:
//   clk  system clock            rst  synchronous active-high reset
//   RxD  async serial line (idles high)
//   rd   read-side interface (master): rd_valid/rd_data/rd_ack, count, frame_err, overrun, err_clr
module uart_rx_buffered #(
  parameter int CLK_FREQ = 0,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  uart_rx_buffered_if.master   rd
);
  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_buffered: CLK_FREQ/(BAUD*16) must be at least 1");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
  state_t             r_state, w_state_n;
  logic               r_s1, r_s2;
  logic [CW-1:0]      r_div;
  logic               w_tick;
  logic               r_armed;
  logic [3:0]         r_sc, w_sc_n;
  logic [2:0]         r_bc, w_bc_n;
  logic [7:0]         r_shift, w_shift_n;
  logic               w_push, w_ferr, w_pop, w_full, w_wr, w_ovr;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_ferr, r_ovr;
  assign w_tick = (r_div == CW'(DIV - 1));
  // Arming needs both sync flops high so the reset value of the synchronizer
  // can never stand in for a genuinely idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_div   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= RxD;
      r_s2    <= r_s1;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_armed <= r_armed | (w_tick & r_s1 & r_s2);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_bc    <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_sc    <= w_sc_n;
      r_bc    <= w_bc_n;
      r_shift <= w_shift_n;
    end
  end
  // sc wraps 15->0 naturally, so DATA->STOP needs no explicit clear.
  always_comb begin
    w_state_n = r_state;
    w_sc_n    = r_sc;
    w_bc_n    = r_bc;
    w_shift_n = r_shift;
    w_push    = 1'b0;
    w_ferr    = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          w_state_n = (r_armed && !r_s2) ? S_START : S_IDLE;
          w_sc_n    = '0;
        end
        S_START: begin
          w_sc_n = r_sc + 4'd1;
          if (r_sc == 4'd7) begin
            w_state_n = r_s2 ? S_IDLE : S_DATA;
            w_sc_n    = '0;
            w_bc_n    = '0;
          end
        end
        S_DATA: begin
          w_sc_n = r_sc + 4'd1;
          if (r_sc == 4'd15) begin
            w_shift_n = {r_s2, r_shift[7:1]};
            w_bc_n    = r_bc + 3'd1;
            w_state_n = (r_bc == 3'd7) ? S_STOP : S_DATA;
          end
        end
        S_STOP: begin
          w_sc_n = r_sc + 4'd1;
          if (r_sc == 4'd15) begin
            w_push    = r_s2;
            w_ferr    = !r_s2;
            w_state_n = r_s2 ? S_IDLE : S_BRK;
          end
        end
        S_BRK:   w_state_n = r_s2 ? S_IDLE : S_BRK;
        default: w_state_n = S_IDLE;
      endcase
    end
  end
  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // with a simultaneous pop is accepted without overrun.
  assign w_full = (r_cnt == (FIFO_AW+1)'(DEPTH));
  assign w_pop  = rd.rd_ack && (r_cnt != '0);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovr  = w_push && w_full && !w_pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) r_mem[r_wp] <= r_shift;
      r_wp   <= r_wp + FIFO_AW'(w_wr);
      r_rp   <= r_rp + FIFO_AW'(w_pop);
      r_cnt  <= r_cnt + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_pop);
      r_ferr <= rd.err_clr ? 1'b0 : (r_ferr | w_ferr);
      r_ovr  <= rd.err_clr ? 1'b0 : (r_ovr | w_ovr);
    end
  end
  assign rd.rd_valid  = (r_cnt != '0);
  assign rd.rd_data   = r_mem[r_rp];
  assign rd.count     = r_cnt;
  assign rd.frame_err = r_ferr;
  assign rd.overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed self-checking bench for uart_rx_buffered (DIV=2, 32 clk/bit)
module tb_uart_rx_buffered;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RxD = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   k;
  uart_rx_buffered_if #(.FIFO_AW(2)) rd_if ();
  uart_rx_buffered #(.CLK_FREQ(3686400), .BAUD(115200), .FIFO_AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .RxD(RxD),
    .rd (rd_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] b);
    hold(1'b0, 32);
    for (int i = 0; i < 8; i++) hold(b[i], 32);
  endtask
  task automatic send(input logic [7:0] b);
    send_bits(b);
    hold(1'b1, 32);
  endtask
  task automatic pop();
    rd_if.rd_ack = 1'b1;
    @(negedge clk);
    rd_if.rd_ack = 1'b0;
  endtask
  task automatic clr_err();
    rd_if.err_clr = 1'b1;
    @(negedge clk);
    rd_if.err_clr = 1'b0;
  endtask
  task automatic read_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_if.rd_data), 32'(exp));
    pop();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rd_if.rd_ack  = 1'b0;
    rd_if.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_count", 32'(rd_if.count), 32'd0);
    check("rst_ferr", 32'(rd_if.frame_err), 32'd0);
    check("rst_ovr", 32'(rd_if.overrun), 32'd0);
    check("rst_data", 32'(rd_if.rd_data), 32'd0);
    rst = 1'b0;
    hold(1'b1, 10);
    // 1: single byte
    send(8'hA5);
    check("t1_count", 32'(rd_if.count), 32'd1);
    read_expect("t1", 8'hA5);
    check("t1_empty", 32'(rd_if.rd_valid), 32'd0);
    check("t1_count0", 32'(rd_if.count), 32'd0);
    // 2: overrun with five back-to-back bytes
    for (int i = 1; i <= 5; i++) send(8'(i));
    check("t2_count", 32'(rd_if.count), 32'd4);
    check("t2_ovr", 32'(rd_if.overrun), 32'd1);
    for (int i = 1; i <= 4; i++) read_expect("t2_rd", 8'(i));
    check("t2_empty", 32'(rd_if.rd_valid), 32'd0);
    clr_err();
    check("t2_ovr_clr", 32'(rd_if.overrun), 32'd0);
    // 3: start-bit glitch
    hold(1'b0, 8);
    hold(1'b1, 40);
    check("t3_count", 32'(rd_if.count), 32'd0);
    check("t3_ferr", 32'(rd_if.frame_err), 32'd0);
    send(8'h3C);
    read_expect("t3", 8'h3C);
    // 4: framing error with long low stop bit
    send_bits(8'h55);
    hold(1'b0, 64);
    check("t4_ferr", 32'(rd_if.frame_err), 32'd1);
    check("t4_count", 32'(rd_if.count), 32'd0);
    hold(1'b1, 32);
    send(8'h0F);
    check("t4_count1", 32'(rd_if.count), 32'd1);
    check("t4_ferr_sticky", 32'(rd_if.frame_err), 32'd1);
    read_expect("t4", 8'h0F);
    clr_err();
    check("t4_ferr_clr", 32'(rd_if.frame_err), 32'd0);
    // 5: full FIFO, pop coincident with the fifth push
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    check("t5_full", 32'(rd_if.count), 32'd4);
    k = 0;
    fork
      send(8'h14);
      begin
        while (!dut.w_push && k < 400) begin
          @(negedge clk);
          k++;
        end
        check("t5_push_seen", 32'(k < 400), 32'd1);
        pop();
      end
    join
    check("t5_count", 32'(rd_if.count), 32'd4);
    check("t5_ovr", 32'(rd_if.overrun), 32'd0);
    for (int i = 1; i <= 4; i++) read_expect("t5_rd", 8'h10 + 8'(i));
    // 6: reset mid-frame during a break
    hold(1'b0, 144);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 200);
    check("t6_valid", 32'(rd_if.rd_valid), 32'd0);
    check("t6_count", 32'(rd_if.count), 32'd0);
    check("t6_ferr", 32'(rd_if.frame_err), 32'd0);
    hold(1'b1, 40);
    send(8'h81);
    check("t6_count1", 32'(rd_if.count), 32'd1);
    read_expect("t6", 8'h81);
    check("t6_ferr_end", 32'(rd_if.frame_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
